// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern driver.
// Holds the pattern-mode enum and the entry value of each pattern.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_BLINK   = 2'd1,
    LED_CHASE   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_t;

  localparam logic [3:0] CHASE_INIT = 4'b0001;
  localparam logic [3:0] BLINK_INIT = 4'b1111;

  // Pattern register value on entry to a mode.
  // BREATHE derives the LEDs from PWM, so its entry is dark.
  function automatic logic [3:0] entry_pat(
    input led_mode_t m
  );
    logic [3:0] p;
    p = 4'b0000;
    unique case (m)
      LED_BLINK: p = BLINK_INIT;
      LED_CHASE: p = CHASE_INIT;
      default:   p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last count.
// Ports: clk, rst (async high), tick_o (1-cycle pulse).
module led_tick_gen #(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Drives four LEDs with off/blink/chase/PWM-breathe patterns.
// Ports: clk, rst, mode/mode_vld/mode_rdy, pio_led, step.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int TICK_DIV   = 50_000,
  parameter int STEP_TICKS = 256,
  parameter int PWM_BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  led_mode_t  mode,
  input  logic       mode_vld,
  output logic       mode_rdy,
  output logic [3:0] pio_led,
  output logic       step
);

  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [PWM_BITS-1:0] P_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] P_MAX = '1;

  logic tick;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  led_mode_t         state_q, state_d;
  led_mode_t         pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [SW-1:0]     step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic              dn_q, dn_d;
  logic [3:0]        pat_q, pat_d;
  logic [3:0]        led_q, led_d;
  logic              step_q, step_d;

  logic accept;
  logic apply;
  logic step_hit;

  // A request is held while one is pending, so ready is
  // simply the absence of a pending request.
  assign mode_rdy = ~pend_vld_q;
  assign pio_led  = led_q;
  assign step     = step_q;

  assign accept   = mode_vld & ~pend_vld_q;
  // Only a pend registered on an earlier edge can apply, so an
  // accept coincident with tick waits for the next tick.
  assign apply    = tick & pend_vld_q;
  assign step_hit = tick & (step_cnt_q == STEP_LAST);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    step_cnt_d = step_cnt_q;
    pwm_d      = pwm_q + P_ONE;
    duty_d     = duty_q;
    dn_d       = dn_q;
    pat_d      = pat_q;
    step_d     = 1'b0;

    if (accept) begin
      pend_d     = mode;
      pend_vld_d = 1'b1;
    end

    if (apply) begin
      state_d    = pend_q;
      pend_vld_d = 1'b0;
      step_cnt_d = '0;
      pat_d      = entry_pat(pend_q);
      duty_d     = '0;
      dn_d       = 1'b0;
    end else if (tick) begin
      step_cnt_d = step_hit ? '0 : step_cnt_q + S_ONE;
      unique case (state_q)
        LED_OFF: ;
        LED_BLINK: begin
          if (step_hit) begin
            pat_d  = ~pat_q;
            step_d = 1'b1;
          end
        end
        LED_CHASE: begin
          if (step_hit) begin
            pat_d  = {pat_q[2:0], pat_q[3]};
            step_d = 1'b1;
          end
        end
        LED_BREATHE: begin
          step_d = 1'b1;
          if (!dn_q) begin
            if (duty_q == P_MAX) begin
              duty_d = duty_q - P_ONE;
              dn_d   = 1'b1;
            end else begin
              duty_d = duty_q + P_ONE;
            end
          end else begin
            if (duty_q == '0) begin
              duty_d = P_ONE;
              dn_d   = 1'b0;
            end else begin
              duty_d = duty_q - P_ONE;
            end
          end
        end
        default: ;
      endcase
    end

    if (!apply && state_q == LED_BREATHE) begin
      led_d = {4{pwm_q < duty_q}};
    end else begin
      led_d = pat_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LED_OFF;
      pend_q     <= LED_OFF;
      pend_vld_q <= 1'b0;
      step_cnt_q <= '0;
      pwm_q      <= '0;
      duty_q     <= '0;
      dn_q       <= 1'b0;
      pat_q      <= 4'b0000;
      led_q      <= 4'b0000;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      step_cnt_q <= step_cnt_d;
      pwm_q      <= pwm_d;
      duty_q     <= duty_d;
      dn_q       <= dn_d;
      pat_q      <= pat_d;
      led_q      <= led_d;
      step_q     <= step_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver.
// Small prescaler/step values keep every event short.
module tb_led_pattern_driver;
  import led_pkg::*;

  logic       clk;
  logic       rst;
  led_mode_t  mode;
  logic       mode_vld;
  logic       mode_rdy;
  logic [3:0] pio_led;
  logic       step;

  int tests;
  int fails;
  int ec;

  led_pattern_driver #(
    .TICK_DIV   (4),
    .STEP_TICKS (4),
    .PWM_BITS   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .mode_vld (mode_vld),
    .mode_rdy (mode_rdy),
    .pio_led  (pio_led),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ec++;
    end
  endtask

  task automatic goto(input int e);
    while (ec < e) advance(1);
  endtask

  task automatic request(input led_mode_t m);
    mode     = m;
    mode_vld = 1'b1;
    advance(1);
    mode_vld = 1'b0;
  endtask

  function automatic int next_tick(input int e);
    return (e / 4 + 1) * 4;
  endfunction

  initial begin
    logic [3:0] chase_seq [4];
    int bad;
    int acc;
    int ap;
    int ap2;
    int w;

    tests    = 0;
    fails    = 0;
    ec       = 0;
    rst      = 1'b0;
    mode     = LED_OFF;
    mode_vld = 1'b0;
    chase_seq[0] = 4'b0010;
    chase_seq[1] = 4'b0100;
    chase_seq[2] = 4'b1000;
    chase_seq[3] = 4'b0001;

    // async reset before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_led", 32'(pio_led), 32'h0);
    chk("rst_rdy", 32'(mode_rdy), 32'h1);
    chk("rst_step", 32'(step), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ec  = 0;

    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      advance(1);
      if (pio_led !== 4'b0000 || step !== 1'b0) bad++;
    end
    chk("idle_off", 32'(bad), 32'h0);

    // CHASE
    request(LED_CHASE);
    acc = ec;
    chk("chase_rdy_low", 32'(mode_rdy), 32'h0);
    ap = next_tick(acc);
    goto(ap - 1);
    chk("chase_pre", 32'(pio_led), 32'h0);
    goto(ap);
    chk("chase_entry", 32'(pio_led), 32'h1);
    chk("chase_rdy_back", 32'(mode_rdy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      goto(ap + 16 * (i + 1) - 1);
      chk("chase_hold_step", 32'(step), 32'h0);
      goto(ap + 16 * (i + 1));
      chk("chase_led", 32'(pio_led), 32'(chase_seq[i]));
      chk("chase_step", 32'(step), 32'h1);
      advance(1);
      chk("chase_step_fall", 32'(step), 32'h0);
    end

    // BLINK
    request(LED_BLINK);
    ap = next_tick(ec);
    goto(ap);
    chk("blink_entry", 32'(pio_led), 32'hF);
    goto(ap + 15);
    chk("blink_hold", 32'(pio_led), 32'hF);
    goto(ap + 16);
    chk("blink_off", 32'(pio_led), 32'h0);
    chk("blink_step", 32'(step), 32'h1);
    goto(ap + 32);
    chk("blink_on", 32'(pio_led), 32'hF);

    // held request while not ready
    mode     = LED_CHASE;
    mode_vld = 1'b1;
    advance(1);
    acc  = ec;
    ap   = next_tick(acc);
    mode = LED_BLINK;
    goto(ap - 1);
    chk("hold_rdy_low", 32'(mode_rdy), 32'h0);
    chk("hold_led", 32'(pio_led), 32'hF);
    goto(ap);
    chk("hold_chase", 32'(pio_led), 32'h1);
    chk("hold_rdy_up", 32'(mode_rdy), 32'h1);
    advance(1);
    mode_vld = 1'b0;
    chk("hold_accepted", 32'(mode_rdy), 32'h0);
    ap2 = ap + 4;
    goto(ap2 - 1);
    chk("hold_pre", 32'(pio_led), 32'h1);
    goto(ap2);
    chk("hold_blink", 32'(pio_led), 32'hF);
    chk("hold_rdy_once", 32'(mode_rdy), 32'h1);

    // accept in the tick cycle: applies one tick later
    goto(ap2 + 3);
    request(LED_CHASE);
    acc = ec;
    chk("coin_rdy", 32'(mode_rdy), 32'h0);
    chk("coin_not_now", 32'(pio_led), 32'hF);
    goto(acc + 3);
    chk("coin_wait", 32'(pio_led), 32'hF);
    goto(acc + 4);
    chk("coin_apply", 32'(pio_led), 32'h1);

    // BREATHE
    request(LED_BREATHE);
    ap = next_tick(ec);
    goto(ap);
    chk("br_entry", 32'(pio_led), 32'h0);
    goto(ap + 4);
    chk("br_duty1", 32'(dut.duty_q), 32'd1);
    chk("br_step", 32'(step), 32'h1);
    advance(1);
    chk("br_step_fall", 32'(step), 32'h0);
    // pwm_cnt == edges since reset mod 256; w is its next wrap
    w = (ap / 256 + 1) * 256;
    goto(w);
    chk("br_duty_w", 32'(dut.duty_q), 32'((w - ap) / 4));
    chk("br_pwm255", 32'(pio_led), 32'h0);
    advance(1);
    chk("br_pwm0", 32'(pio_led), 32'hF);
    goto(ap + 1020);
    chk("br_max", 32'(dut.duty_q), 32'd255);
    goto(ap + 1024);
    chk("br_turn", 32'(dut.duty_q), 32'd254);
    goto(ap + 2040);
    chk("br_zero", 32'(dut.duty_q), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      advance(1);
      if (pio_led !== 4'b0000) bad++;
    end
    chk("br_zero_dark", 32'(bad), 32'h0);
    chk("br_up", 32'(dut.duty_q), 32'd1);

    // reset mid-CHASE with BREATHE pending
    request(LED_CHASE);
    ap = next_tick(ec);
    goto(ap);
    chk("r6_chase", 32'(pio_led), 32'h1);
    request(LED_BREATHE);
    chk("r6_pending", 32'(mode_rdy), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("r6_led", 32'(pio_led), 32'h0);
    chk("r6_rdy", 32'(mode_rdy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    ec  = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      advance(1);
      if (step !== 1'b0 || mode_rdy !== 1'b1 ||
          pio_led !== 4'b0000) bad++;
    end
    chk("r6_no_pending", 32'(bad), 32'h0);
    chk("r6_state", 32'(dut.state_q), 32'(LED_OFF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
